// File: rtl/hazard_forward_ctrl_if.sv
// Hazard/forwarding controller bundle: ID-stage metadata and
// pipeline status in, forwarding selects and stall/flush out.
interface hazard_forward_ctrl_if #(
    parameter int XREG_W = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [XREG_W-1:0] id_rs1;
    logic [XREG_W-1:0] id_rs2;
    logic [XREG_W-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              branch_taken;
    logic              mem_ready;

    logic              fwd_a_en;
    logic              fwd_b_en;
    logic              fwd_a_src;
    logic              fwd_b_src;
    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              stall_mem;
    logic              flush_id;
    logic              bubble_ex;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd,
        output id_reg_write, id_mem_read, id_mem_write,
        output branch_taken, mem_ready,
        input  fwd_a_en, fwd_b_en, fwd_a_src, fwd_b_src,
        input  stall_if, stall_id, stall_ex, stall_mem,
        input  flush_id, bubble_ex, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd,
        input  id_reg_write, id_mem_read, id_mem_write,
        input  branch_taken, mem_ready,
        output fwd_a_en, fwd_b_en, fwd_a_src, fwd_b_src,
        output stall_if, stall_id, stall_ex, stall_mem,
        output flush_id, bubble_ex, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Shadows EX/MEM/WB register-use metadata and derives operand
// forwarding selects plus stall/flush controls for the pipeline.
module hazard_forward_ctrl #(
    parameter int XREG_W = 5,
    parameter int CNT_W  = 16
) (
    input logic             clk,
    input logic             rst_n,
    hazard_forward_ctrl_if.slave hz
);

    typedef struct packed {
        logic              valid;
        logic [XREG_W-1:0] rs1;
        logic [XREG_W-1:0] rs2;
        logic [XREG_W-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_op;
    } ex_slot_t;

    typedef struct packed {
        logic              valid;
        logic [XREG_W-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_op;
    } mem_slot_t;

    typedef struct packed {
        logic              valid;
        logic [XREG_W-1:0] rd;
        logic              reg_write;
    } wb_slot_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    ex_slot_t  ex_q;
    mem_slot_t mem_q;
    wb_slot_t  wb_q;
    state_t    state_q, state_d;
    ex_slot_t  id_slot;
    logic      mem_wait, branch, load_use;

    // {en, src}; MEM wins over WB, loads in MEM cannot forward yet
    function automatic logic [1:0] fwd_sel(
        input logic [XREG_W-1:0] rs,
        input mem_slot_t         m,
        input wb_slot_t          w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (m.valid && m.reg_write && !m.mem_read && m.rd == rs)
                sel = 2'b10;
            else if (w.valid && w.reg_write && w.rd == rs)
                sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        id_slot           = '0;
        id_slot.valid     = hz.id_valid;
        id_slot.rs1       = hz.id_rs1;
        id_slot.rs2       = hz.id_rs2;
        id_slot.rd        = hz.id_rd;
        id_slot.reg_write = hz.id_reg_write && (hz.id_rd != '0);
        id_slot.mem_read  = hz.id_mem_read;
        id_slot.mem_op    = hz.id_mem_read || hz.id_mem_write;
    end

    assign mem_wait = mem_q.valid && mem_q.mem_op && !hz.mem_ready;
    assign branch   = !mem_wait && hz.branch_taken && ex_q.valid;
    assign load_use = !mem_wait && !branch && ex_q.valid &&
                      ex_q.mem_read && (ex_q.rd != '0) && hz.id_valid &&
                      (ex_q.rd == hz.id_rs1 || ex_q.rd == hz.id_rs2);

    always_comb begin
        {hz.fwd_a_en, hz.fwd_a_src} = fwd_sel(ex_q.rs1, mem_q, wb_q);
        {hz.fwd_b_en, hz.fwd_b_src} = fwd_sel(ex_q.rs2, mem_q, wb_q);
        hz.stall_if  = mem_wait || load_use;
        hz.stall_id  = mem_wait || load_use;
        hz.stall_ex  = mem_wait;
        hz.stall_mem = mem_wait;
        hz.flush_id  = branch;
        hz.bubble_ex = branch || load_use;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (mem_wait)      state_d = MEM_WAIT;
                else if (load_use) state_d = LU_STALL;
            end
            LU_STALL: state_d = mem_wait ? MEM_WAIT : RUN;
            MEM_WAIT: if (!mem_wait) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // frozen: EX and MEM hold, WB drains to a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (mem_wait) begin
            wb_q  <= '0;
        end else begin
            wb_q.valid     <= mem_q.valid;
            wb_q.rd        <= mem_q.rd;
            wb_q.reg_write <= mem_q.reg_write;
            mem_q.valid     <= ex_q.valid;
            mem_q.rd        <= ex_q.rd;
            mem_q.reg_write <= ex_q.reg_write;
            mem_q.mem_read  <= ex_q.mem_read;
            mem_q.mem_op    <= ex_q.mem_op;
            if (load_use || branch || !hz.id_valid)
                ex_q <= '0;
            else
                ex_q <= id_slot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz.stall_cnt <= '0;
        end else if (hz.stall_id && (hz.stall_cnt != '1)) begin
            hz.stall_cnt <= hz.stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed checks of forwarding selects, load-use, branch flush,
// memory-wait freeze, reset and stall counter saturation.
module tb_hazard_forward_ctrl;

    localparam int XW = 5;
    localparam int CW = 3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    hazard_forward_ctrl_if #(.XREG_W(XW), .CNT_W(CW)) hz ();

    hazard_forward_ctrl #(.XREG_W(XW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // [9]a_en [8]a_src [7]b_en [6]b_src [5]s_if [4]s_id
    // [3]s_ex [2]s_mem [1]flush_id [0]bubble_ex
    function automatic logic [9:0] outs();
        return {hz.fwd_a_en, hz.fwd_a_src, hz.fwd_b_en, hz.fwd_b_src,
                hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem,
                hz.flush_id, hz.bubble_ex};
    endfunction

    task automatic cyc(
        input logic          v,
        input logic [XW-1:0] rs1,
        input logic [XW-1:0] rs2,
        input logic [XW-1:0] rd,
        input logic          rw,
        input logic          mr,
        input logic          mw,
        input logic          br,
        input logic          rdy
    );
        @(posedge clk);
        #1;
        hz.id_valid     = v;
        hz.id_rs1       = rs1;
        hz.id_rs2       = rs2;
        hz.id_rd        = rd;
        hz.id_reg_write = rw;
        hz.id_mem_read  = mr;
        hz.id_mem_write = mw;
        hz.branch_taken = br;
        hz.mem_ready    = rdy;
        #1;
    endtask

    task automatic nop(input logic rdy);
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) nop(1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        hz.id_valid     = 1'b1;
        hz.id_rs1       = 5'd3;
        hz.id_rs2       = 5'd4;
        hz.id_rd        = 5'd3;
        hz.id_reg_write = 1'b1;
        hz.id_mem_read  = 1'b1;
        hz.id_mem_write = 1'b0;
        hz.branch_taken = 1'b1;
        hz.mem_ready    = 1'b0;
        #12;
        total++;
        if (outs() !== 10'b0) begin
            bad++;
            $display("FAIL reset_outs got=%b exp=%b", outs(), 10'b0);
        end
        total++;
        if (hz.stall_cnt !== 3'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d exp=0", hz.stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drain();
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(1'b1);
        total++;
        if (outs() !== 10'b1000000000) begin
            bad++;
            $display("FAIL b2b_mem_fwd got=%b exp=%b", outs(), 10'b1000000000);
        end
        drain();
    endtask

    task automatic test_one_apart();
        cyc(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'd0, 5'd7, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(1'b1);
        total++;
        if (outs() !== 10'b0011000000) begin
            bad++;
            $display("FAIL wb_fwd got=%b exp=%b", outs(), 10'b0011000000);
        end
        drain();
        cyc(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'd0, 5'd7, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(1'b1);
        total++;
        if (outs() !== 10'b0010000000) begin
            bad++;
            $display("FAIL mem_over_wb got=%b exp=%b", outs(), 10'b0010000000);
        end
        drain();
    endtask

    task automatic test_x0_guard();
        cyc(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(1'b1);
        total++;
        if (outs() !== 10'b0) begin
            bad++;
            $display("FAIL x0_guard got=%b exp=%b", outs(), 10'b0);
        end
        drain();
    endtask

    task automatic test_load_use();
        cyc(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'd6, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (outs() !== 10'b0000110001) begin
            bad++;
            $display("FAIL lu_stall got=%b exp=%b", outs(), 10'b0000110001);
        end
        cyc(1'b1, 5'd6, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (outs() !== 10'b0) begin
            bad++;
            $display("FAIL lu_one_cycle got=%b exp=%b", outs(), 10'b0);
        end
        total++;
        if (hz.stall_cnt !== 3'd1) begin
            bad++;
            $display("FAIL lu_cnt got=%0d exp=1", hz.stall_cnt);
        end
        nop(1'b1);
        total++;
        if (outs() !== 10'b1100000000) begin
            bad++;
            $display("FAIL lu_wb_fwd got=%b exp=%b", outs(), 10'b1100000000);
        end
        drain();
    endtask

    task automatic test_branch_over_lu();
        cyc(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'd6, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        total++;
        if (outs() !== 10'b0000000011) begin
            bad++;
            $display("FAIL br_flush got=%b exp=%b", outs(), 10'b0000000011);
        end
        nop(1'b1);
        total++;
        if (hz.stall_cnt !== 3'd1) begin
            bad++;
            $display("FAIL br_cnt got=%0d exp=1", hz.stall_cnt);
        end
        drain();
    endtask

    task automatic test_mem_wait();
        do_reset();
        cyc(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, i == 1, 1'b0);
            total++;
            if (outs() !== 10'b0000111100) begin
                bad++;
                $display("FAIL wait_stall[%0d] got=%b exp=%b", i, outs(), 10'b0000111100);
            end
        end
        nop(1'b1);
        total++;
        if (outs() !== 10'b0) begin
            bad++;
            $display("FAIL wait_resume got=%b exp=%b", outs(), 10'b0);
        end
        total++;
        if (hz.stall_cnt !== 3'd3) begin
            bad++;
            $display("FAIL wait_cnt got=%0d exp=3", hz.stall_cnt);
        end
        drain();
    endtask

    task automatic test_reset_mid_wait();
        cyc(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(1'b0);
        total++;
        if (outs() !== 10'b0000111100) begin
            bad++;
            $display("FAIL rst_wait_pre got=%b exp=%b", outs(), 10'b0000111100);
        end
        nop(1'b0);
        rst_n = 1'b0;
        #1;
        total++;
        if (outs() !== 10'b0 || hz.stall_cnt !== 3'd0) begin
            bad++;
            $display("FAIL rst_mid got=%b cnt=%0d exp=%b cnt=0", outs(), hz.stall_cnt, 10'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 5'd2, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (outs() !== 10'b0) begin
            bad++;
            $display("FAIL rst_release got=%b exp=%b", outs(), 10'b0);
        end
        drain();
    endtask

    task automatic test_cnt_saturate();
        do_reset();
        cyc(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        nop(1'b1);
        for (int i = 0; i < 10; i++) nop(1'b0);
        total++;
        if (hz.stall_cnt !== 3'd7 || outs() !== 10'b0000111100) begin
            bad++;
            $display("FAIL cnt_sat got=%0d/%b exp=7/%b", hz.stall_cnt, outs(), 10'b0000111100);
        end
        drain();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_back_to_back();
        test_one_apart();
        test_x0_guard();
        test_load_use();
        test_branch_over_lu();
        test_mem_wait();
        test_reset_mid_wait();
        test_cnt_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard and forwarding controller for the 5-stage core. It keeps a shadow copy of the register-use metadata for the EX, MEM and WB stages. From that it drives the select lines of the two-level 2:1 operand-forwarding mux chain in front of the ALU, and the stall and flush controls for the IF/ID/EX/MEM pipeline registers. It is the decision side of the forwarding datapath: the muxes consume its selects; this block produces them.

## Interface
Parameters:
- XREG_W, 5, register index width
- CNT_W, 16, width of the stall performance counter

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- ID_VALID  in  1  ID stage holds a real instruction
- ID_RS1, ID_RS2, ID_RD  in  XREG_W  register indices of the ID instruction
- ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE  in  1  ID instruction control bits
- BRANCH_TAKEN  in  1  EX-stage branch/jump resolved taken
- MEM_READY  in  1  data memory completes the MEM-stage access this cycle
- FWD_A_EN, FWD_B_EN  out  1  outer mux select: 0 = register file, 1 = forwarded value
- FWD_A_SRC, FWD_B_SRC  out  1  inner mux select: 0 = MEM ALU result, 1 = WB write data
- STALL_IF, STALL_ID, STALL_EX, STALL_MEM  out  1  hold the corresponding pipeline register
- FLUSH_ID, BUBBLE_EX  out  1  clear the IF/ID register; load a NOP into ID/EX
- STALL_CNT  out  CNT_W  saturating count of cycles with STALL_ID=1

## Operation
- Each slot (EX, MEM, WB) holds {valid, rs1, rs2, rd, reg_write, mem_read, mem_op}. A slot whose rd==0 is treated as reg_write=0.
- Advance (state RUN, no freeze):
  - EX ← ID fields, or a bubble (valid=0) when a stall or flush is raised.
  - MEM ← EX.
  - WB ← MEM.
- Forwarding for EX operand A (B is identical, using rs2):
  - MEM.valid && MEM.reg_write && !MEM.mem_read && MEM.rd==EX.rs1 && EX.rs1!=0 → EN=1, SRC=0.
  - Otherwise, WB.valid && WB.reg_write && WB.rd==EX.rs1 && EX.rs1!=0 → EN=1, SRC=1.
  - Otherwise EN=0, SRC=0. MEM has priority over WB.
- Load-use is detected when EX.valid && EX.mem_read && EX.rd!=0 && ID_VALID && (EX.rd==ID_RS1 || EX.rd==ID_RS2).
  - Response: STALL_IF=STALL_ID=1 and BUBBLE_EX=1.
  - The FSM moves to LU_STALL for exactly one cycle.
- Taken branch: BRANCH_TAKEN=1 with EX.valid → FLUSH_ID=1 and BUBBLE_EX=1. It overrides load-use in the same cycle; no load-use stall is taken.
- Memory wait: MEM.valid && MEM.mem_op && !MEM_READY → all four STALL_* = 1.
  - EX and MEM slots hold; WB ← bubble.
  - BRANCH_TAKEN is ignored while frozen and re-evaluated when the freeze ends.
  - Memory wait has highest priority.
- FSM states:
  - RUN: default.
  - LU_STALL: one cycle, then returns to RUN.
  - MEM_WAIT: entered on a memory wait; stays there while MEM_READY=0; returns to RUN on the cycle MEM_READY=1.
  - A memory wait arising in LU_STALL goes to MEM_WAIT.
- STALL_CNT increments on each cycle with STALL_ID=1 and saturates at all-ones.

## Timing
- Reset (RST_N=0, asynchronous):
  - All slots invalid and FSM = RUN.
  - STALL_CNT = 0.
  - Every output is 0.
- Outputs are combinational from the registered slots, FSM state and current inputs. They are valid in the same cycle, before the edge they act on.
- Load-use costs exactly 1 stall cycle. The dependent instruction then forwards from WB (SRC=1).
- A taken branch costs 2 squashed instructions: the ID instruction and the one fetched the same cycle, which the fetch unit redirects.
- Reset asserted mid-stall or mid-wait clears everything immediately. The first cycle after release is RUN with no forwarding.

## Test plan
- Back-to-back ALU ops: add x5 in MEM, EX reads rs1=x5 → FWD_A_EN=1, FWD_A_SRC=0, no stall.
- One-apart dependency: WB writes x7, EX rs2=x7, MEM rd=x3 → FWD_B_EN=1, FWD_B_SRC=1. With MEM rd=x7 as well → SRC=0.
- x0 guard: MEM and WB write rd=0, EX rs1=0 → FWD_A_EN=0.
- Load-use: lw x6 in EX, ID_RS1=6 → STALL_IF/STALL_ID/BUBBLE_EX=1 for 1 cycle. Next cycle FWD_A_EN=1, SRC=1, and STALL_CNT=1.
- Load-use plus BRANCH_TAKEN in the same cycle → FLUSH_ID=1, BUBBLE_EX=1, STALL_ID=0, STALL_CNT unchanged.
- Store in MEM with MEM_READY low for 3 cycles → all STALL_*=1 for 3 cycles and STALL_CNT=3; RUN resumes on the 4th cycle. Asserting RST_N=0 in cycle 2 → all outputs 0 immediately.
